sha256_padder: RTL and testbench

- Upstream stage of sha256_core.
- Accepts a message as a stream of 32-bit big-endian words with valid/ready handshake.
- Assembles 512-bit blocks and applies FIPS 180-4 padding: 0x80 marker, zero fill, 64-bit big-endian bit length.
- Presents each block with a last-block flag through a valid/ready handshake; block_ready is driven by the core's block-load strobe.

---
 rtl/sha256_padder_if.sv | 24 ++
 rtl/sha256_padder.sv | 166 ++++++++++++++++
 tb/tb_sha256_padder.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/sha256_padder_if.sv
// Bundles the word-stream input and the padded-block output of sha256_padder.
// Both handshakes follow one rule: a transfer happens on a rising clk edge where valid and ready are both 1.
// Once valid is raised, its payload stays stable until that transfer happens.
interface sha256_padder_if;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic [2:0]   in_bytes;
    logic [511:0] block;
    logic         block_valid;
    logic         block_last;
    logic         block_ready;

    modport master (
        output in_valid, in_data, in_last, in_bytes, block_ready,
        input  in_ready, block, block_valid, block_last
    );

    modport slave (
        input  in_valid, in_data, in_last, in_bytes, block_ready,
        output in_ready, block, block_valid, block_last
    );
endinterface

// File: rtl/sha256_padder.sv
// Assembles 32-bit big-endian message words into 512-bit SHA-256 blocks.
// Applies the 0x80 marker, zero fill and 64-bit length, adding an extra block when the tail does not fit.
module sha256_padder (
    input  logic            clk,
    input  logic            reset,
    sha256_padder_if.slave  bus,
    output logic [1:0]      o_state
);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_EMIT  = 2'd1,
        S_EXTRA = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [3:0]   r_widx;
    logic [63:0]  r_len;
    logic [63:0]  r_len_final;
    logic         r_extra_pending;
    logic         r_marker_done;
    logic [511:0] r_block;
    logic         r_block_last;

    logic         w_in_ready;
    logic         w_block_valid;
    logic [2:0]   w_nb;
    logic [31:0]  w_mask;
    logic [31:0]  w_marker;
    logic [6:0]   w_n;
    logic [63:0]  w_len_final;
    logic [511:0] w_last_block;
    logic [511:0] w_extra_block;
    logic [4:0]   w_widx_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_in_ready    = 1'b0;
        w_block_valid = 1'b0;
        case (r_state)
            S_FILL: begin
                w_in_ready = 1'b1;
                if (bus.in_valid && (bus.in_last || r_widx == 4'd15)) begin
                    w_state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                w_block_valid = 1'b1;
                if (bus.block_ready) begin
                    w_state_nxt = r_extra_pending ? S_EXTRA : S_FILL;
                end
            end
            S_EXTRA: begin
                w_block_valid = 1'b1;
                if (bus.block_ready) begin
                    w_state_nxt = S_FILL;
                end
            end
            default: w_state_nxt = S_FILL;
        endcase
    end

    // Final-word padding: n = bytes of the message that land in this block.
    always_comb begin
        w_nb = (bus.in_bytes > 3'd4) ? 3'd4 : bus.in_bytes;
        case (w_nb)
            3'd0:    begin w_mask = 32'h0000_0000; w_marker = 32'h8000_0000; end
            3'd1:    begin w_mask = 32'hFF00_0000; w_marker = 32'h0080_0000; end
            3'd2:    begin w_mask = 32'hFFFF_0000; w_marker = 32'h0000_8000; end
            3'd3:    begin w_mask = 32'hFFFF_FF00; w_marker = 32'h0000_0080; end
            default: begin w_mask = 32'hFFFF_FFFF; w_marker = 32'h0000_0000; end
        endcase
        w_n         = {1'b0, r_widx, 2'b00} + {4'b0000, w_nb};
        w_len_final = r_len + {58'd0, w_nb, 3'b000};
        w_widx_p1   = {1'b0, r_widx} + 5'd1;

        w_last_block = '0;
        for (int k = 0; k < 16; k++) begin
            if (4'(k) < r_widx) begin
                w_last_block[511 - 32*k -: 32] = r_block[511 - 32*k -: 32];
            end else if (4'(k) == r_widx) begin
                w_last_block[511 - 32*k -: 32] = (bus.in_data & w_mask) | w_marker;
            end else if (5'(k) == w_widx_p1 && w_nb == 3'd4) begin
                w_last_block[511 - 32*k -: 32] = 32'h8000_0000;
            end
        end
        if (w_n <= 7'd55) begin
            w_last_block[63:0] = w_len_final;
        end

        w_extra_block = {(r_marker_done ? 32'h0000_0000 : 32'h8000_0000), 416'd0, r_len_final};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_widx          <= 4'd0;
            r_len           <= 64'd0;
            r_len_final     <= 64'd0;
            r_extra_pending <= 1'b0;
            r_marker_done   <= 1'b0;
            r_block         <= '0;
            r_block_last    <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (bus.in_valid && !bus.in_last) begin
                        r_block[9'd511 - {r_widx, 5'b00000} -: 32] <= bus.in_data;
                        r_len        <= r_len + 64'd32;
                        r_widx       <= r_widx + 4'd1;
                        r_block_last <= 1'b0;
                    end else if (bus.in_valid) begin
                        r_block     <= w_last_block;
                        r_len_final <= w_len_final;
                        r_widx      <= 4'd0;
                        if (w_n <= 7'd55) begin
                            r_block_last    <= 1'b1;
                            r_extra_pending <= 1'b0;
                        end else begin
                            r_block_last    <= 1'b0;
                            r_extra_pending <= 1'b1;
                            r_marker_done   <= (w_n != 7'd64);
                        end
                    end
                end
                S_EMIT: begin
                    if (bus.block_ready) begin
                        if (r_extra_pending) begin
                            r_block      <= w_extra_block;
                            r_block_last <= 1'b1;
                        end else begin
                            if (r_block_last) begin
                                r_len  <= 64'd0;
                                r_widx <= 4'd0;
                            end
                            r_block_last <= 1'b0;
                        end
                    end
                end
                S_EXTRA: begin
                    if (bus.block_ready) begin
                        r_len           <= 64'd0;
                        r_extra_pending <= 1'b0;
                        r_block_last    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.block_valid = w_block_valid;
    assign bus.block       = r_block;
    assign bus.block_last  = r_block_last;
    assign o_state         = r_state;

endmodule

// File: tb/tb_sha256_padder.sv
// Drives byte messages into sha256_padder and compares every block against a FIPS 180-4 padding model.
module tb_sha256_padder;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] dbg_state;

    sha256_padder_if bus ();

    sha256_padder dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .o_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0]   msg[$];
    logic [512:0] exp_q[$];

    task automatic chk(input string tag, input logic [512:0] obs, input logic [512:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference padding: message bytes, 0x80, zeros to 56 mod 64, then the 64-bit bit length.
    task automatic build_exp();
        logic [7:0]   pad[$];
        logic [63:0]  bits;
        logic [511:0] b;
        int           nblk;
        pad = msg;
        pad.push_back(8'h80);
        while (pad.size() % 64 != 56) pad.push_back(8'h00);
        bits = 64'(msg.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) pad.push_back(bits[8*i +: 8]);
        nblk = pad.size() / 64;
        exp_q.delete();
        for (int blk = 0; blk < nblk; blk++) begin
            for (int j = 0; j < 64; j++) b[511 - 8*j -: 8] = pad[64*blk + j];
            exp_q.push_back({(blk == nblk - 1), b});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"},    513'(bus.in_ready),    513'd1);
        chk({tag, "_block_valid"}, 513'(bus.block_valid), 513'd0);
        chk({tag, "_block_last"},  513'(bus.block_last),  513'd0);
        chk({tag, "_block"},       513'(bus.block),       513'd0);
    endtask

    task automatic run_msg(input int rdy_pct, input int hold);
        int nw, wi, drv_wi, taken, completed, total, cyc, hold_left, rem, idx;
        bit prev_valid, prev_take, take;
        logic [512:0] prev_out;
        build_exp();
        total     = exp_q.size();
        nw        = (msg.size() == 0) ? 1 : (msg.size() + 3) / 4;
        rem       = msg.size() - 4 * (nw - 1);
        wi        = 0;
        drv_wi    = -1;
        taken     = 0;
        completed = 0;
        cyc       = 0;
        hold_left = hold;
        prev_valid = 1'b0;
        prev_take  = 1'b0;
        prev_out   = '0;
        while (taken < total && cyc < 4000) begin
            @(negedge clk);
            if (wi < nw) begin
                if (wi != drv_wi) begin
                    for (int b = 0; b < 4; b++) begin
                        idx = 4 * wi + b;
                        bus.in_data[31 - 8*b -: 8] = (idx < msg.size()) ? msg[idx] : 8'($urandom);
                    end
                    bus.in_last = (wi == nw - 1);
                    if (wi == nw - 1)
                        bus.in_bytes = (rem == 4) ? 3'($urandom_range(4, 7)) : 3'(rem);
                    else
                        bus.in_bytes = 3'($urandom);
                    drv_wi = wi;
                end
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
                bus.in_last  = 1'b0;
            end
            if (bus.block_valid && hold_left > 0) begin
                bus.block_ready = 1'b0;
                hold_left--;
            end else begin
                bus.block_ready = ($urandom_range(0, 99) < rdy_pct);
            end

            chk("in_ready", 513'(bus.in_ready), 513'(taken == completed));
            chk("block_valid", 513'(bus.block_valid), 513'(taken != completed));
            if (prev_valid && !prev_take && bus.block_valid)
                chk("hold_stable", {bus.block_last, bus.block}, prev_out);

            take = bus.block_valid && bus.block_ready;
            if (take && exp_q.size() > 0) begin
                chk("block", {bus.block_last, bus.block}, exp_q.pop_front());
                taken++;
            end
            if (bus.in_valid && bus.in_ready) begin
                if (bus.in_last) completed = total;
                else if ((wi + 1) % 16 == 0) completed++;
                wi++;
            end
            prev_valid = bus.block_valid;
            prev_take  = take;
            prev_out   = {bus.block_last, bus.block};
            cyc++;
        end
        chk("blocks_taken", 513'(taken), 513'(total));
        @(negedge clk);
        bus.in_valid    = 1'b0;
        bus.in_last     = 1'b0;
        bus.block_ready = 1'b0;
    endtask

    task automatic set_random_msg(input int nbytes);
        msg.delete();
        for (int i = 0; i < nbytes; i++) msg.push_back(8'($urandom));
    endtask

    task automatic set_abc();
        msg.delete();
        msg.push_back(8'h61);
        msg.push_back(8'h62);
        msg.push_back(8'h63);
    endtask

    initial begin
        reset           = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.in_last     = 1'b0;
        bus.in_bytes    = '0;
        bus.block_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

        set_abc();
        run_msg(100, 0);

        set_random_msg(0);
        run_msg(100, 0);

        set_random_msg(56);
        run_msg(70, 0);

        set_random_msg(64);
        run_msg(70, 0);

        set_random_msg(100);
        run_msg(100, 10);

        for (int t = 0; t < 20; t++) begin
            set_random_msg($urandom_range(0, 200));
            run_msg($urandom_range(30, 100), $urandom_range(0, 3));
        end

        // Partial message interrupted by reset must leave no trace.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = $urandom;
            bus.in_last  = 1'b0;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        reset = 1'b0;

        set_abc();
        run_msg(100, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
